// File: rtl/imem_loader_if.sv
// Byte stream and instruction-memory write port of the boot loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  // Stream source / controller side
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_write, mem_addr, mem_wdata, cpu_hold, done, error
  );

  // Loader side
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_write, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a count/words/checksum byte stream,
// writes each word to instruction memory and holds the CPU while loading.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BCNT_W = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    idx;
  logic [BCNT_W-1:0]   bcnt;
  logic [BYTE_W-1:0]   csum;
  logic [WORD_W-1:0]   word;

  logic                accept_c;
  logic [CNT_W-1:0]    hdr_count_c;
  logic [WORD_W-1:0]   word_c;
  logic [CNT_W-1:0]    idx_inc_c;

  assign accept_c    = bus.byte_valid & bus.byte_ready;
  assign hdr_count_c = {count[BYTE_W-1:0], bus.byte_in};
  assign word_c      = {word[WORD_W-BYTE_W-1:0], bus.byte_in};
  assign idx_inc_c   = idx + CNT_W'(1);

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (accept_c && bcnt == BCNT_W'(1)) begin
          if (32'(hdr_count_c) > 32'(MAX_WORDS)) state_nxt = S_ERR;
          else if (hdr_count_c == '0)            state_nxt = S_CSUM;
          else                                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept_c && bcnt == BCNT_W'(3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = (idx_inc_c == count) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept_c) state_nxt = (bus.byte_in == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      count          <= '0;
      idx            <= '0;
      bcnt           <= '0;
      csum           <= '0;
      word           <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cpu_hold   <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.byte_ready <= (state_nxt == S_HDR) || (state_nxt == S_DATA) ||
                        (state_nxt == S_CSUM);
      bus.mem_write  <= (state_nxt == S_WRITE);
      bus.cpu_hold   <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      bus.done       <= (state_nxt == S_DONE);
      bus.error      <= (state_nxt == S_ERR);

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            count <= '0;
            idx   <= '0;
            bcnt  <= '0;
            csum  <= '0;
            word  <= '0;
          end
        end
        S_HDR: begin
          if (accept_c) begin
            count <= hdr_count_c;
            csum  <= csum ^ bus.byte_in;
            bcnt  <= (bcnt == BCNT_W'(1)) ? '0 : bcnt + BCNT_W'(1);
          end
        end
        S_DATA: begin
          if (accept_c) begin
            word <= word_c;
            csum <= csum ^ bus.byte_in;
            bcnt <= bcnt + BCNT_W'(1);
            // Address and data are captured as the word completes so they
            // are stable for the single WRITE cycle and held afterwards.
            if (bcnt == BCNT_W'(3)) begin
              bus.mem_addr  <= BASE_ADDR + (32'(idx) << 2);
              bus.mem_wdata <= word_c;
            end
          end
        end
        S_WRITE: begin
          idx <= idx_inc_c;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
